wb_bus_arbiter: RTL and testbench

Arbitrates the single writeback/forwarding bus (common data bus) among the functional units that produce results (ALU, load/store unit, spare), one result per cycle.
Buffers each unit's results in a small per-source FIFO and selects among the FIFOs round-robin.
Drives a registered broadcast that feeds both the reorder buffer writeback port (valid/idx/value) and the issue-queue forwarding port (fwd_rd/fwd_rd_val).
Sits between the execute stage and the reorder_buffer/issue_queue.

---
 rtl/wb_bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_wb_bus_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_arbiter.sv
// Writeback bus arbiter: per-source result FIFOs feeding one registered
// broadcast (ROB writeback + issue-queue forwarding), granted round-robin.
module wb_bus_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int PREG_W  = 6,
  parameter int ROB_W   = 6,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 2,
  localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        req_valid,
  output logic [NUM_SRC-1:0]        req_ready,
  input  logic [NUM_SRC*PREG_W-1:0] req_preg,
  input  logic [NUM_SRC*ROB_W-1:0]  req_rob_idx,
  input  logic [NUM_SRC*DATA_W-1:0] req_value,
  output logic                      wb_valid,
  output logic [PREG_W-1:0]         wb_preg,
  output logic [ROB_W-1:0]          wb_rob_idx,
  output logic [DATA_W-1:0]         wb_value,
  output logic [SRC_W-1:0]          wb_src,
  output logic [15:0]               conflict_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = PREG_W + ROB_W + DATA_W;

  logic [ENT_W-1:0] mem [NUM_SRC][DEPTH];
  logic [PTR_W-1:0] wr_ptr [NUM_SRC];
  logic [PTR_W-1:0] rd_ptr [NUM_SRC];
  logic [CNT_W-1:0] count [NUM_SRC];
  logic [ENT_W-1:0] head [NUM_SRC];

  logic [NUM_SRC-1:0] non_empty;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [SRC_W-1:0]   last;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W-1:0]   cand;
  logic               grant_valid;
  logic               seen_one;
  logic               multi_req;

  // Ready/occupancy flags come only from registered counts; flush blocks both push and pop
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      req_ready[i] = (count[i] != CNT_W'(DEPTH));
      non_empty[i] = (count[i] != '0);
      head[i]      = mem[i][rd_ptr[i]];
      push[i]      = req_valid[i] && req_ready[i] && !flush;
      pop[i]       = grant_valid && (grant_idx == SRC_W'(i)) && !flush;
    end
  end

  // Round-robin search starting just after the last granted source
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = SRC_W'((int'(last) + k) % NUM_SRC);
      if (!grant_valid && non_empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Detect cycles where two or more FIFOs compete for the bus
  always_comb begin
    seen_one  = 1'b0;
    multi_req = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (non_empty[i]) begin
        if (seen_one) multi_req = 1'b1;
        seen_one = 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset because counts gate visibility
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= {req_preg[i*PREG_W +: PREG_W],
                              req_rob_idx[i*ROB_W +: ROB_W],
                              req_value[i*DATA_W +: DATA_W]};
      end
    end
  end

  // FIFO pointers and counts; flush empties every FIFO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        if (push[i] && !pop[i])      count[i] <= count[i] + CNT_W'(1);
        else if (!push[i] && pop[i]) count[i] <= count[i] - CNT_W'(1);
      end
    end
  end

  // Registered broadcast; payload holds when idle, last pointer survives flush
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid   <= 1'b0;
      wb_preg    <= '0;
      wb_rob_idx <= '0;
      wb_value   <= '0;
      wb_src     <= '0;
      last       <= SRC_W'(NUM_SRC - 1);
    end else if (flush) begin
      wb_valid <= 1'b0;
    end else if (grant_valid) begin
      wb_valid                          <= 1'b1;
      {wb_preg, wb_rob_idx, wb_value}   <= head[grant_idx];
      wb_src                            <= grant_idx;
      last                              <= grant_idx;
    end else begin
      wb_valid <= 1'b0;
    end
  end

  // Saturating contention counter, unaffected by flush
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conflict_cnt <= '0;
    end else if (multi_req && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed testbench for wb_bus_arbiter with hand-computed expectations.
module tb_wb_bus_arbiter;

  localparam int NUM_SRC = 3;
  localparam int PREG_W  = 6;
  localparam int ROB_W   = 6;
  localparam int DATA_W  = 32;

  logic                      clk;
  logic                      reset_n;
  logic                      flush;
  logic [NUM_SRC-1:0]        req_valid;
  logic [NUM_SRC-1:0]        req_ready;
  logic [NUM_SRC*PREG_W-1:0] req_preg;
  logic [NUM_SRC*ROB_W-1:0]  req_rob_idx;
  logic [NUM_SRC*DATA_W-1:0] req_value;
  logic                      wb_valid;
  logic [PREG_W-1:0]         wb_preg;
  logic [ROB_W-1:0]          wb_rob_idx;
  logic [DATA_W-1:0]         wb_value;
  logic [1:0]                wb_src;
  logic [15:0]               conflict_cnt;

  int check_cnt;
  int fail_cnt;

  wb_bus_arbiter #(
    .NUM_SRC(NUM_SRC), .PREG_W(PREG_W), .ROB_W(ROB_W), .DATA_W(DATA_W), .DEPTH(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_preg(req_preg), .req_rob_idx(req_rob_idx), .req_value(req_value),
    .wb_valid(wb_valid), .wb_preg(wb_preg), .wb_rob_idx(wb_rob_idx),
    .wb_value(wb_value), .wb_src(wb_src), .conflict_cnt(conflict_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Standard payload for source s, entry k
  function automatic logic [31:0] pay(input int s, input int k);
    return 32'hA000_0000 | (s << 8) | k;
  endfunction

  task automatic apply_stimulus(input int s, input logic v, input logic [5:0] p,
                                input logic [5:0] r, input logic [31:0] d);
    req_valid[s]              = v;
    req_preg[s*PREG_W +: PREG_W] = p;
    req_rob_idx[s*ROB_W +: ROB_W] = r;
    req_value[s*DATA_W +: DATA_W] = d;
  endtask

  task automatic push_std(input int s, input int k);
    apply_stimulus(s, 1'b1, 6'(s * 8 + k), 6'(k), pay(s, k));
  endtask

  task automatic idle_all();
    for (int s = 0; s < NUM_SRC; s++) req_valid[s] = 1'b0;
  endtask

  task automatic check_wb(input string tag, input int s, input int k);
    check_output({tag, "_valid"}, 32'(wb_valid), 32'd1);
    check_output({tag, "_src"},   32'(wb_src),   32'(s));
    check_output({tag, "_value"}, wb_value,      pay(s, k));
  endtask

  task automatic do_reset();
    idle_all();
    flush   = 1'b0;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    check_cnt   = 0;
    fail_cnt    = 0;
    flush       = 1'b0;
    reset_n     = 1'b0;
    req_valid   = '0;
    req_preg    = '0;
    req_rob_idx = '0;
    req_value   = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_wb_valid", 32'(wb_valid), 32'd0);
    check_output("rst_wb_preg", 32'(wb_preg), 32'd0);
    check_output("rst_wb_rob", 32'(wb_rob_idx), 32'd0);
    check_output("rst_wb_value", wb_value, 32'd0);
    check_output("rst_wb_src", 32'(wb_src), 32'd0);
    check_output("rst_conflict", 32'(conflict_cnt), 32'd0);
    reset_n = 1'b1;
    #1;
    check_output("rst_ready", 32'(req_ready), 32'h7);

    // Single source: presented after edge 0, accepted at edge 1, broadcast after edge 2
    tick();
    apply_stimulus(1, 1'b1, 6'd5, 6'd3, 32'hDEADBEEF);
    tick();
    idle_all();
    check_output("single_no_bypass", 32'(wb_valid), 32'd0);
    tick();
    check_output("single_valid", 32'(wb_valid), 32'd1);
    check_output("single_preg", 32'(wb_preg), 32'd5);
    check_output("single_rob", 32'(wb_rob_idx), 32'd3);
    check_output("single_value", wb_value, 32'hDEADBEEF);
    check_output("single_src", 32'(wb_src), 32'd1);
    tick();
    check_output("single_done", 32'(wb_valid), 32'd0);

    // Round robin: two entries from each source, order 0,1,2,0,1,2
    do_reset();
    tick();
    for (int s = 0; s < NUM_SRC; s++) push_std(s, 0);
    tick();
    for (int s = 0; s < NUM_SRC; s++) push_std(s, 1);
    tick();
    idle_all();
    check_wb("rr0", 0, 0);
    check_output("rr0_preg", 32'(wb_preg), 32'd0);
    tick(); check_wb("rr1", 1, 0);
    tick(); check_wb("rr2", 2, 0);
    tick(); check_wb("rr3", 0, 1);
    tick(); check_wb("rr4", 1, 1);
    check_output("rr4_preg", 32'(wb_preg), 32'd9);
    tick(); check_wb("rr5", 2, 1);
    tick();
    check_output("rr_drained", 32'(wb_valid), 32'd0);
    // Contended edges: before grants 1..5 at least two FIFOs hold data
    check_output("rr_conflict", 32'(conflict_cnt), 32'd5);

    // Backpressure on src0 while src1/src2 share the bus
    do_reset();
    tick();
    push_std(0, 0); push_std(1, 0); push_std(2, 0);
    tick();
    check_output("bp_ready_a", 32'(req_ready), 32'h7);
    push_std(0, 1); push_std(1, 1); push_std(2, 1);
    tick();
    check_wb("bp_b", 0, 0);
    check_output("bp_ready_b", 32'(req_ready), 32'h1);
    idle_all();
    push_std(0, 2);
    tick();
    check_wb("bp_c", 1, 0);
    check_output("bp_ready_c", 32'(req_ready), 32'h2);
    push_std(0, 3);
    tick();
    check_wb("bp_d", 2, 0);
    check_output("bp_ready_d", 32'(req_ready), 32'h6);
    tick();
    check_wb("bp_e", 0, 1);
    check_output("bp_ready_e", 32'(req_ready), 32'h7);
    tick();
    check_wb("bp_f", 1, 1);
    check_output("bp_ready_f", 32'(req_ready), 32'h6);
    idle_all();
    tick(); check_wb("bp_g", 2, 1);
    tick(); check_wb("bp_h", 0, 2);
    tick(); check_wb("bp_i", 0, 3);
    tick();
    check_output("bp_drained", 32'(wb_valid), 32'd0);

    // Flush with four entries buffered and a same-cycle push from src0
    do_reset();
    tick();
    for (int s = 0; s < NUM_SRC; s++) push_std(s, 0);
    tick();
    idle_all();
    push_std(1, 1); push_std(2, 1);
    tick();
    check_wb("fl_pre", 0, 0);
    idle_all();
    flush = 1'b1;
    push_std(0, 7);
    tick();
    flush = 1'b0;
    idle_all();
    check_output("fl_ready", 32'(req_ready), 32'h7);
    check_output("fl_valid", 32'(wb_valid), 32'd0);
    tick();
    check_output("fl_quiet1", 32'(wb_valid), 32'd0);
    tick();
    check_output("fl_quiet2", 32'(wb_valid), 32'd0);
    for (int s = 0; s < NUM_SRC; s++) push_std(s, 2);
    tick();
    idle_all();
    tick();
    check_wb("fl_resume", 1, 2);

    // Asynchronous reset between edges while a result is on the bus
    #2;
    reset_n = 1'b0;
    #1;
    check_output("ar_valid", 32'(wb_valid), 32'd0);
    check_output("ar_src", 32'(wb_src), 32'd0);
    check_output("ar_conflict", 32'(conflict_cnt), 32'd0);
    #1;
    reset_n = 1'b1;
    tick();
    for (int s = 0; s < NUM_SRC; s++) push_std(s, 3);
    tick();
    idle_all();
    tick();
    check_wb("ar_first", 0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", check_cnt, fail_cnt);
    $finish;
  end

endmodule
